// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - two-master AHB-Lite arbiter with burst lock, default parking and split address/data ownership
module ahb_master_arbiter #(
  parameter logic DEFAULT_MASTER = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_busreq_i,
  input  logic [1:0]  m0_htrans_i,
  input  logic [31:0] m0_haddr_i,
  input  logic        m0_hwrite_i,
  input  logic [2:0]  m0_hsize_i,
  input  logic [2:0]  m0_hburst_i,
  input  logic [31:0] m0_hwdata_i,
  input  logic        m1_busreq_i,
  input  logic [1:0]  m1_htrans_i,
  input  logic [31:0] m1_haddr_i,
  input  logic        m1_hwrite_i,
  input  logic [2:0]  m1_hsize_i,
  input  logic [2:0]  m1_hburst_i,
  input  logic [31:0] m1_hwdata_i,
  output logic        m0_hgrant_o,
  output logic        m1_hgrant_o,
  output logic        m_hready_o,
  output logic [31:0] m_hrdata_o,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;

  logic       addr_owner;
  logic       data_owner;
  logic       dphase_active;
  logic       next_owner;
  logic       own_req;
  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       burst_lock;

  assign own_req   = addr_owner ? m1_busreq_i : m0_busreq_i;
  assign own_trans = addr_owner ? m1_htrans_i : m0_htrans_i;
  assign own_burst = addr_owner ? m1_hburst_i : m0_hburst_i;

  assign HTRANS = (rst_ni && own_req) ? own_trans : TR_IDLE;
  assign HADDR  = addr_owner ? m1_haddr_i  : m0_haddr_i;
  assign HWRITE = addr_owner ? m1_hwrite_i : m0_hwrite_i;
  assign HSIZE  = addr_owner ? m1_hsize_i  : m0_hsize_i;
  assign HBURST = own_burst;
  assign HWDATA = data_owner ? m1_hwdata_i : m0_hwdata_i;

  assign m_hrdata_o  = HRDATA;
  assign m_hready_o  = HREADY;
  assign m0_hgrant_o = (addr_owner == 1'b0);
  assign m1_hgrant_o = (addr_owner == 1'b1);

  // The opening NONSEQ of a multi-beat burst locks too, so its SEQ beats stay with the owner.
  assign burst_lock = own_req &&
                      ((own_trans == TR_SEQ) || (own_trans == TR_BUSY) ||
                       ((own_trans == TR_NONSEQ) && (own_burst != BURST_SINGLE)));

  always_comb begin
    next_owner = addr_owner;
    if (burst_lock) begin
      next_owner = addr_owner;
    end else if (m0_busreq_i && m1_busreq_i) begin
      next_owner = (HTRANS == TR_NONSEQ) ? ~addr_owner : addr_owner;
    end else if (m0_busreq_i) begin
      next_owner = 1'b0;
    end else if (m1_busreq_i) begin
      next_owner = 1'b1;
    end else begin
      next_owner = DEFAULT_MASTER;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_owner    <= DEFAULT_MASTER;
      data_owner    <= DEFAULT_MASTER;
      dphase_active <= 1'b0;
    end else if (HREADY) begin
      addr_owner    <= next_owner;
      data_owner    <= addr_owner;
      dphase_active <= (HTRANS != TR_IDLE);
    end
  end

  a_dphase_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!HREADY && dphase_active) |=> dphase_active);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed vector bench for ahb_master_arbiter
module tb_ahb_master_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_busreq_i, m1_busreq_i;
  logic [1:0]  m0_htrans_i, m1_htrans_i;
  logic [31:0] m0_haddr_i, m1_haddr_i;
  logic        m0_hwrite_i, m1_hwrite_i;
  logic [2:0]  m0_hsize_i, m1_hsize_i;
  logic [2:0]  m0_hburst_i, m1_hburst_i;
  logic [31:0] m0_hwdata_i, m1_hwdata_i;
  logic        m0_hgrant_o, m1_hgrant_o;
  logic        m_hready_o;
  logic [31:0] m_hrdata_o;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  int n_vec  = 0;
  int n_fail = 0;

  ahb_master_arbiter #(.DEFAULT_MASTER(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_busreq_i(m0_busreq_i), .m0_htrans_i(m0_htrans_i), .m0_haddr_i(m0_haddr_i),
    .m0_hwrite_i(m0_hwrite_i), .m0_hsize_i(m0_hsize_i), .m0_hburst_i(m0_hburst_i),
    .m0_hwdata_i(m0_hwdata_i),
    .m1_busreq_i(m1_busreq_i), .m1_htrans_i(m1_htrans_i), .m1_haddr_i(m1_haddr_i),
    .m1_hwrite_i(m1_hwrite_i), .m1_hsize_i(m1_hsize_i), .m1_hburst_i(m1_hburst_i),
    .m1_hwdata_i(m1_hwdata_i),
    .m0_hgrant_o(m0_hgrant_o), .m1_hgrant_o(m1_hgrant_o),
    .m_hready_o(m_hready_o), .m_hrdata_o(m_hrdata_o),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        m0_req;
    logic [1:0]  m0_trans;
    logic        m1_req;
    logic [1:0]  m1_trans;
    logic        hready;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic [31:0] e_hwdata;
    logic        e_g0;
    logic        e_g1;
    logic        e_dph;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m0_busreq_i = 0; m0_htrans_i = 2'b00; m0_haddr_i = 32'h1000; m0_hwrite_i = 1;
    m0_hsize_i = 3'd2; m0_hburst_i = 3'b000; m0_hwdata_i = 32'hAAAA0000;
    m1_busreq_i = 0; m1_htrans_i = 2'b00; m1_haddr_i = 32'h2000; m1_hwrite_i = 0;
    m1_hsize_i = 3'd1; m1_hburst_i = 3'b000; m1_hwdata_i = 32'hBBBB0000;
    HRDATA = 32'h0; HREADY = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    tick();
    tick();
    rst_ni = 1;
  endtask

  initial begin
    // addr mux: m0 0x1000/write/size2, m1 0x2000/read/size1; HWDATA exposes data_owner
    vecs[0] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 32'h1000, 32'hAAAA0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 32'h2000, 32'hAAAA0000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 32'h1000, 32'hBBBB0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'b10, 32'h2000, 32'hAAAA0000, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 32'h2000, 32'hAAAA0000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00, 32'h1000, 32'hBBBB0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10, 32'h2000, 32'hAAAA0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 32'h2000, 32'hBBBB0000, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 32'h1000, 32'hBBBB0000, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 32'h1000, 32'hAAAA0000, 1'b1, 1'b0, 1'b0};

    // Reset defaults: HTRANS forced idle even with both masters asking
    idle_inputs();
    rst_ni = 0;
    m0_busreq_i = 1; m0_htrans_i = 2'b10;
    m1_busreq_i = 1; m1_htrans_i = 2'b10;
    #2;
    chk("rst_htrans", {30'd0, HTRANS}, 32'h0);
    chk("rst_g0", {31'd0, m0_hgrant_o}, 32'h1);
    chk("rst_g1", {31'd0, m1_hgrant_o}, 32'h0);
    m0_busreq_i = 0; m0_htrans_i = 2'b00;
    tick();
    rst_ni = 1;
    @(negedge clk_i);
    chk("rel_g0", {31'd0, m0_hgrant_o}, 32'h1);
    chk("rel_htrans", {30'd0, HTRANS}, 32'h0);
    chk("rel_dph", {31'd0, dut.dphase_active}, 32'h0);
    tick();
    @(negedge clk_i);
    chk("rel_g1", {31'd0, m1_hgrant_o}, 32'h1);
    chk("rel_htrans_m1", {30'd0, HTRANS}, 32'h2);
    chk("rel_haddr_m1", HADDR, 32'h2000);

    // Alternation, wait-state hold, idle parking
    do_reset();
    for (int i = 0; i < 10; i++) begin
      m0_busreq_i = vecs[i].m0_req; m0_htrans_i = vecs[i].m0_trans;
      m1_busreq_i = vecs[i].m1_req; m1_htrans_i = vecs[i].m1_trans;
      HREADY = vecs[i].hready;
      @(negedge clk_i);
      chk($sformatf("v%0d_htrans", i), {30'd0, HTRANS}, {30'd0, vecs[i].e_htrans});
      chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].e_haddr);
      chk($sformatf("v%0d_hwrite", i), {31'd0, HWRITE}, {31'd0, vecs[i].e_g0});
      chk($sformatf("v%0d_hsize", i), {29'd0, HSIZE}, vecs[i].e_g0 ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].e_hwdata);
      chk($sformatf("v%0d_g0", i), {31'd0, m0_hgrant_o}, {31'd0, vecs[i].e_g0});
      chk($sformatf("v%0d_g1", i), {31'd0, m1_hgrant_o}, {31'd0, vecs[i].e_g1});
      chk($sformatf("v%0d_hready", i), {31'd0, m_hready_o}, {31'd0, vecs[i].hready});
      chk($sformatf("v%0d_dph", i), {31'd0, dut.dphase_active}, {31'd0, vecs[i].e_dph});
      tick();
    end

    // Wait states in m0's data phase while m1 requests
    do_reset();
    m0_busreq_i = 1; m0_htrans_i = 2'b10; m0_haddr_i = 32'h10;
    @(negedge clk_i);
    chk("ws_haddr", HADDR, 32'h10);
    chk("ws_htrans", {30'd0, HTRANS}, 32'h2);
    tick();
    m0_busreq_i = 0; m0_htrans_i = 2'b00; m0_hwdata_i = 32'hDEADBEEF;
    m1_busreq_i = 1; m1_htrans_i = 2'b10;
    HREADY = 0; HRDATA = 32'h12345678;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk_i);
      chk($sformatf("ws%0d_hwdata", w), HWDATA, 32'hDEADBEEF);
      chk($sformatf("ws%0d_g1", w), {31'd0, m1_hgrant_o}, 32'h0);
      chk($sformatf("ws%0d_dph", w), {31'd0, dut.dphase_active}, 32'h1);
      tick();
    end
    chk("ws_hrdata", m_hrdata_o, 32'h12345678);
    HREADY = 1;
    @(negedge clk_i);
    chk("ws_last_hwdata", HWDATA, 32'hDEADBEEF);
    chk("ws_last_g1", {31'd0, m1_hgrant_o}, 32'h0);
    tick();
    @(negedge clk_i);
    chk("ws_after_g1", {31'd0, m1_hgrant_o}, 32'h1);
    chk("ws_after_haddr", HADDR, 32'h2000);

    // Burst lock: m1 INCR4 while m0 keeps requesting
    do_reset();
    m1_busreq_i = 1; m1_htrans_i = 2'b00;
    tick();
    m1_hburst_i = 3'b011;
    m0_busreq_i = 1; m0_htrans_i = 2'b10;
    for (int b = 0; b < 4; b++) begin
      m1_htrans_i = (b == 0) ? 2'b10 : 2'b11;
      m1_haddr_i = 32'h3000 + 32'(4 * b);
      @(negedge clk_i);
      chk($sformatf("bl%0d_g1", b), {31'd0, m1_hgrant_o}, 32'h1);
      chk($sformatf("bl%0d_haddr", b), HADDR, 32'h3000 + 32'(4 * b));
      chk($sformatf("bl%0d_htrans", b), {30'd0, HTRANS}, (b == 0) ? 32'h2 : 32'h3);
      chk($sformatf("bl%0d_hburst", b), {29'd0, HBURST}, 32'h3);
      tick();
    end
    m1_busreq_i = 0; m1_htrans_i = 2'b00;
    @(negedge clk_i);
    chk("bl_end_g1", {31'd0, m1_hgrant_o}, 32'h1);
    chk("bl_end_htrans", {30'd0, HTRANS}, 32'h0);
    tick();
    @(negedge clk_i);
    chk("bl_m0_g0", {31'd0, m0_hgrant_o}, 32'h1);
    chk("bl_m0_haddr", HADDR, 32'h1000);
    chk("bl_m0_htrans", {30'd0, HTRANS}, 32'h2);

    // Reset asserted mid data phase during a wait state
    m0_busreq_i = 0; m0_htrans_i = 2'b00; m0_hwdata_i = 32'h0BADF00D;
    m1_busreq_i = 1; m1_htrans_i = 2'b10; m1_hburst_i = 3'b000;
    tick();
    tick();
    m1_hwdata_i = 32'hCAFEF00D;
    HREADY = 0;
    @(negedge clk_i);
    chk("rm_pre_hwdata", HWDATA, 32'hCAFEF00D);
    chk("rm_pre_htrans", {30'd0, HTRANS}, 32'h2);
    #2;
    rst_ni = 0;
    #1;
    chk("rm_g0", {31'd0, m0_hgrant_o}, 32'h1);
    chk("rm_g1", {31'd0, m1_hgrant_o}, 32'h0);
    chk("rm_htrans", {30'd0, HTRANS}, 32'h0);
    chk("rm_hwdata", HWDATA, 32'h0BADF00D);
    chk("rm_dph", {31'd0, dut.dphase_active}, 32'h0);
    tick();
    rst_ni = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
